// File: rtl/capture_framer_pkg.sv
// Shared constants, state encoding and header layout for the ADC capture framer.
package capture_framer_pkg;

  localparam int          DEF_CHANNELS = 8;
  localparam logic [7:0]  DEF_MAGIC    = 8'hA5;
  // Wide enough for CHANNELS up to 63 and for the CHANNELS field of the header.
  localparam int          IDX_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Header layout: [31:24] magic, [23] drop flag, [22] protocol error, [21:16] channel count, [15:0] sequence.
  function automatic logic [31:0] make_header(
    input logic [7:0]       magic,
    input logic             drop_pend,
    input logic             proto_err,
    input logic [IDX_W-1:0] chans,
    input logic [15:0]      seq
  );
    return {magic, drop_pend, proto_err, chans, seq};
  endfunction

endpackage

// File: rtl/capture_framer.sv
// Groups one word per ADC channel into a header-tagged frame and writes it to the capture FIFO,
// dropping whole frames when the FIFO lacks room for a complete frame.
module capture_framer
  import capture_framer_pkg::*;
#(
  parameter int         CHANNELS = DEF_CHANNELS,
  parameter logic [7:0] MAGIC    = DEF_MAGIC
) (
  input  logic        capture_clk,
  input  logic        capture_rst_n,
  input  logic        stream_open,
  input  logic [31:0] in_data,
  input  logic        in_en,
  output logic [31:0] fifo_data,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  input  logic        fifo_almost_full,
  output logic [15:0] drop_count,
  output logic        proto_err
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] CH_IDX    = IDX_W'(CHANNELS);
  localparam int               BUF_AW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int               BUF_DEPTH = 1 << BUF_AW;

  state_t           state_reg;
  logic [15:0]      seq_reg;
  logic [15:0]      drop_count_reg;
  logic             proto_err_reg;
  logic             drop_pend_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic             word_valid_reg;
  logic [31:0]      fifo_data_reg;

  logic [31:0]      frame_buf [BUF_DEPTH];
  logic             buf_we;

  assign buf_we = stream_open && in_en && (state_reg == ST_COLLECT);

  always_ff @(posedge capture_clk) begin
    if (buf_we) begin
      frame_buf[wr_idx_reg[BUF_AW-1:0]] <= in_data;
    end
  end

  // fifo_data_reg holds frame word rd_idx_reg (0 = header); it advances only when the FIFO accepts it.
  always_ff @(posedge capture_clk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      state_reg      <= ST_IDLE;
      seq_reg        <= '0;
      drop_count_reg <= '0;
      proto_err_reg  <= 1'b0;
      drop_pend_reg  <= 1'b0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      word_valid_reg <= 1'b0;
      fifo_data_reg  <= '0;
    end else if (!stream_open) begin
      state_reg      <= ST_IDLE;
      seq_reg        <= '0;
      drop_count_reg <= '0;
      proto_err_reg  <= 1'b0;
      drop_pend_reg  <= 1'b0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_COLLECT;
        end

        ST_COLLECT: begin
          if (in_en) begin
            if (wr_idx_reg == LAST_IDX) begin
              wr_idx_reg <= '0;
              if (fifo_almost_full) begin
                if (drop_count_reg != 16'hFFFF) begin
                  drop_count_reg <= drop_count_reg + 16'd1;
                end
                drop_pend_reg <= 1'b1;
                seq_reg       <= seq_reg + 16'd1;
              end else begin
                state_reg      <= ST_EMIT;
                fifo_data_reg  <= make_header(MAGIC, drop_pend_reg, proto_err_reg, CH_IDX, seq_reg);
                rd_idx_reg     <= '0;
                word_valid_reg <= 1'b1;
              end
            end else begin
              wr_idx_reg <= wr_idx_reg + 1'b1;
            end
          end
        end

        ST_EMIT: begin
          if (in_en) begin
            proto_err_reg <= 1'b1;
          end
          if (word_valid_reg && !fifo_full) begin
            if (rd_idx_reg == CH_IDX) begin
              state_reg      <= ST_COLLECT;
              word_valid_reg <= 1'b0;
              seq_reg        <= seq_reg + 16'd1;
              drop_pend_reg  <= 1'b0;
              wr_idx_reg     <= '0;
              rd_idx_reg     <= '0;
            end else begin
              fifo_data_reg <= frame_buf[rd_idx_reg[BUF_AW-1:0]];
              rd_idx_reg    <= rd_idx_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          word_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Gating with the live full flag keeps the strobe off whenever the FIFO is full; the word stays pending.
  assign fifo_wr_en = word_valid_reg & ~fifo_full;
  assign fifo_data  = fifo_data_reg;
  assign drop_count = drop_count_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_capture_framer.sv
// Directed bench for capture_framer: framing, stalls, drops, protocol errors, close/reopen, sequence wrap.
module tb_capture_framer;

  logic        capture_clk = 1'b0;
  logic        capture_rst_n = 1'b0;
  logic        stream_open = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_en = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_wr_en;
  logic [15:0] drop_count;
  logic        proto_err;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int full_viol = 0;
  logic [31:0] wr_q[$];
  int          wc_q[$];

  capture_framer dut (
    .capture_clk      (capture_clk),
    .capture_rst_n    (capture_rst_n),
    .stream_open      (stream_open),
    .in_data          (in_data),
    .in_en            (in_en),
    .fifo_data        (fifo_data),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .drop_count       (drop_count),
    .proto_err        (proto_err)
  );

  always #5 capture_clk = ~capture_clk;

  always @(posedge capture_clk) cyc <= cyc + 1;

  // Log every write strobe mid-cycle; it is committed at the following rising edge.
  always @(negedge capture_clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_q.push_back(fifo_data);
      wc_q.push_back(cyc);
      if (fifo_full) full_viol++;
    end
  end

  task automatic tick();
    @(posedge capture_clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wc_q.delete();
  endtask

  task automatic feed_frame(input logic [15:0] tag, output int last_cyc);
    for (int k = 0; k < 8; k++) begin
      in_data  = {16'(k + 1), tag};
      in_en    = 1'b1;
      last_cyc = cyc;
      tick();
    end
    in_en = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int budget;
    budget = 60;
    while (wr_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (wr_q.size() < n) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic open_stream();
    stream_open = 1'b1;
    tick();
  endtask

  task automatic close_stream();
    stream_open = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    cmp_cnt++; if (fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_en: got %b, expected 0", fifo_wr_en); end
    cmp_cnt++; if (fifo_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %h, expected 00000000", fifo_data); end
    cmp_cnt++; if (drop_count !== 16'h0) begin err_cnt++; $display("FAIL reset_drop_count: got %h, expected 0000", drop_count); end
    cmp_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL reset_proto_err: got %b, expected 0", proto_err); end
    capture_rst_n = 1'b1;
    tick();
    tick();
    cmp_cnt++; if (fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL closed_wr_en: got %b, expected 0", fifo_wr_en); end
  endtask

  task automatic test_basic_frame();
    int last;
    open_stream();
    clear_log();
    feed_frame(16'hAAAA, last);
    wait_writes(9, "basic");
    cmp_cnt++; if (wr_q[0] !== 32'hA5080000) begin err_cnt++; $display("FAIL basic_header: got %h, expected a5080000", wr_q[0]); end
    for (int k = 1; k <= 8; k++) begin
      cmp_cnt++;
      if (wr_q[k] !== {16'(k), 16'hAAAA}) begin
        err_cnt++; $display("FAIL basic_word%0d: got %h, expected %h", k, wr_q[k], {16'(k), 16'hAAAA});
      end
    end
    cmp_cnt++; if (wc_q[0] !== last + 1) begin err_cnt++; $display("FAIL basic_latency: got cycle %0d, expected %0d", wc_q[0], last + 1); end
    cmp_cnt++; if (wc_q[8] - wc_q[0] !== 8) begin err_cnt++; $display("FAIL basic_span: got %0d, expected 8", wc_q[8] - wc_q[0]); end
    tick(); tick(); tick();
    cmp_cnt++; if (wr_q.size() !== 9) begin err_cnt++; $display("FAIL basic_count: got %0d writes, expected 9", wr_q.size()); end
    $display("basic frame: header %h, %0d writes", wr_q[0], wr_q.size());
  endtask

  task automatic test_fifo_stall();
    int last;
    clear_log();
    feed_frame(16'hCCCC, last);
    wait_writes(3, "stall_pre");
    fifo_full = 1'b1;
    tick(); tick(); tick();
    fifo_full = 1'b0;
    wait_writes(9, "stall");
    cmp_cnt++; if (wr_q[0] !== 32'hA5080001) begin err_cnt++; $display("FAIL stall_header: got %h, expected a5080001", wr_q[0]); end
    for (int k = 1; k <= 8; k++) begin
      cmp_cnt++;
      if (wr_q[k] !== {16'(k), 16'hCCCC}) begin
        err_cnt++; $display("FAIL stall_word%0d: got %h, expected %h", k, wr_q[k], {16'(k), 16'hCCCC});
      end
    end
    cmp_cnt++; if (wc_q[3] - wc_q[2] !== 4) begin err_cnt++; $display("FAIL stall_gap: got %0d, expected 4", wc_q[3] - wc_q[2]); end
    cmp_cnt++; if (wc_q[8] - wc_q[0] !== 11) begin err_cnt++; $display("FAIL stall_span: got %0d, expected 11", wc_q[8] - wc_q[0]); end
    cmp_cnt++; if (full_viol !== 0) begin err_cnt++; $display("FAIL stall_wr_while_full: got %0d, expected 0", full_viol); end
    $display("stall frame: header %h, gap %0d", wr_q[0], wc_q[3] - wc_q[2]);
  endtask

  task automatic test_close_partial();
    int last;
    clear_log();
    for (int k = 0; k < 5; k++) begin
      in_data = {16'(k + 1), 16'h7777};
      in_en   = 1'b1;
      tick();
    end
    in_en = 1'b0;
    stream_open = 1'b0;
    tick(); tick(); tick();
    cmp_cnt++; if (wr_q.size() !== 0) begin err_cnt++; $display("FAIL close_no_writes: got %0d writes, expected 0", wr_q.size()); end
    // Reopen with a word in the same cycle: that word must be ignored.
    stream_open = 1'b1;
    in_en       = 1'b1;
    in_data     = 32'hDEADBEEF;
    tick();
    in_en = 1'b0;
    cmp_cnt++; if (drop_count !== 16'h0) begin err_cnt++; $display("FAIL reopen_drop_count: got %h, expected 0000", drop_count); end
    cmp_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL reopen_proto_err: got %b, expected 0", proto_err); end
    feed_frame(16'h5555, last);
    wait_writes(9, "reopen");
    cmp_cnt++; if (wr_q[0] !== 32'hA5080000) begin err_cnt++; $display("FAIL reopen_header: got %h, expected a5080000", wr_q[0]); end
    cmp_cnt++; if (wr_q[1] !== 32'h00015555) begin err_cnt++; $display("FAIL reopen_word1: got %h, expected 00015555", wr_q[1]); end
    cmp_cnt++; if (wr_q[8] !== 32'h00085555) begin err_cnt++; $display("FAIL reopen_word8: got %h, expected 00085555", wr_q[8]); end
    $display("close/reopen: header %h", wr_q[0]);
  endtask

  task automatic test_drop();
    int last;
    close_stream();
    open_stream();
    clear_log();
    fifo_almost_full = 1'b1;
    feed_frame(16'hD001, last);
    feed_frame(16'hD002, last);
    fifo_almost_full = 1'b0;
    tick(); tick();
    cmp_cnt++; if (drop_count !== 16'd2) begin err_cnt++; $display("FAIL drop_count: got %0d, expected 2", drop_count); end
    cmp_cnt++; if (wr_q.size() !== 0) begin err_cnt++; $display("FAIL drop_no_writes: got %0d writes, expected 0", wr_q.size()); end
    feed_frame(16'hD003, last);
    wait_writes(9, "drop_after");
    cmp_cnt++; if (wr_q[0] !== 32'hA5880002) begin err_cnt++; $display("FAIL drop_header: got %h, expected a5880002", wr_q[0]); end
    cmp_cnt++; if (wr_q[4] !== 32'h0004D003) begin err_cnt++; $display("FAIL drop_word4: got %h, expected 0004d003", wr_q[4]); end
    clear_log();
    feed_frame(16'hD004, last);
    wait_writes(9, "drop_clear");
    cmp_cnt++; if (wr_q[0] !== 32'hA5080003) begin err_cnt++; $display("FAIL drop_flag_clear: got %h, expected a5080003", wr_q[0]); end
    $display("drop: drop_count %0d, header %h", drop_count, wr_q[0]);
  endtask

  task automatic test_proto_err();
    int last;
    clear_log();
    feed_frame(16'hE001, last);
    wait_writes(1, "proto_hdr");
    in_en   = 1'b1;
    in_data = 32'hBAD0BAD0;
    tick();
    in_en = 1'b0;
    wait_writes(9, "proto");
    cmp_cnt++; if (proto_err !== 1'b1) begin err_cnt++; $display("FAIL proto_err_set: got %b, expected 1", proto_err); end
    cmp_cnt++; if (wr_q[0] !== 32'hA5080004) begin err_cnt++; $display("FAIL proto_header0: got %h, expected a5080004", wr_q[0]); end
    for (int k = 1; k <= 8; k++) begin
      cmp_cnt++;
      if (wr_q[k] !== {16'(k), 16'hE001}) begin
        err_cnt++; $display("FAIL proto_word%0d: got %h, expected %h", k, wr_q[k], {16'(k), 16'hE001});
      end
    end
    clear_log();
    feed_frame(16'hE002, last);
    wait_writes(9, "proto_next");
    cmp_cnt++; if (wr_q[0] !== 32'hA5480005) begin err_cnt++; $display("FAIL proto_header1: got %h, expected a5480005", wr_q[0]); end
    cmp_cnt++; if (wr_q[1] !== 32'h0001E002) begin err_cnt++; $display("FAIL proto_realign: got %h, expected 0001e002", wr_q[1]); end
    close_stream();
    cmp_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL proto_err_close: got %b, expected 0", proto_err); end
    cmp_cnt++; if (drop_count !== 16'h0) begin err_cnt++; $display("FAIL close_drop_count: got %h, expected 0000", drop_count); end
    $display("proto_err: flagged header %h", wr_q[0]);
  endtask

  task automatic test_seq_wrap();
    int last;
    open_stream();
    force dut.seq_reg = 16'hFFFF;
    tick();
    release dut.seq_reg;
    clear_log();
    feed_frame(16'hF001, last);
    wait_writes(9, "wrap_ffff");
    cmp_cnt++; if (wr_q[0] !== 32'hA508FFFF) begin err_cnt++; $display("FAIL wrap_ffff: got %h, expected a508ffff", wr_q[0]); end
    clear_log();
    feed_frame(16'hF002, last);
    wait_writes(9, "wrap_zero");
    cmp_cnt++; if (wr_q[0] !== 32'hA5080000) begin err_cnt++; $display("FAIL wrap_zero: got %h, expected a5080000", wr_q[0]); end
    $display("seq wrap: header %h", wr_q[0]);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fifo_stall();
    test_close_partial();
    test_drop();
    test_proto_err();
    test_seq_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
